// File: rtl/imme_buf_sched.sv
// Intermediate-buffer BRAM scheduler: port A collects pooled beats, port B replays them as
// KxK windows or a linear sweep. Optional macro IMME_RD_STALL_EN adds i_rd_stall to pause reads.
module imme_buf_sched #(
  parameter int ADDR_W      = 10,
  parameter int DATA_W      = 48,
  parameter int ADDR_STRIDE = 6
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic              cfg_mode,
  input  logic [3:0]        cfg_map_w,
  input  logic [2:0]        cfg_kernel,
  input  logic [7:0]        cfg_wr_count,
  input  logic              wr_valid,
  input  logic [DATA_W-1:0] wr_data,
`ifdef IMME_RD_STALL_EN
  input  logic              i_rd_stall,
`endif
  output logic              ena,
  output logic              wea,
  output logic [ADDR_W-1:0] addra,
  output logic [DATA_W-1:0] dina,
  output logic              enb,
  output logic [ADDR_W-1:0] addrb,
  output logic              o_rd_valid,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_err
);

  localparam logic [ADDR_W-1:0] STRIDE_A = ADDR_W'(ADDR_STRIDE);

  typedef enum logic [2:0] {S_IDLE, S_FILL, S_DRAIN, S_FLUSH, S_DONE} state_t;

  state_t            state_q, state_d;
  logic              mode_q, mode_d;
  logic [3:0]        m_q, m_d;
  logic [2:0]        k_q, k_d;
  logic [7:0]        n_q, n_d;
  logic [7:0]        wr_cnt_q, wr_cnt_d;
  logic [7:0]        lin_q, lin_d;
  logic [3:0]        oy_q, oy_d, ox_q, ox_d;
  logic [2:0]        ky_q, ky_d, kx_q, kx_d;
  logic              ena_q, ena_d;
  logic [ADDR_W-1:0] addra_q, addra_d;
  logic [DATA_W-1:0] dina_q, dina_d;
  logic              enb_q, enb_d;
  logic [ADDR_W-1:0] addrb_q, addrb_d;
  logic              rd_valid_q, rd_valid_d;
  logic              err_q, err_d;

  logic              rd_stall, cfg_ok, last_beat, last_read, rd_go;
  logic [3:0]        span;
  logic [2:0]        k_last;
  logic [ADDR_W-1:0] row_a, col_a, win_addr, lin_addr;

`ifdef IMME_RD_STALL_EN
  assign rd_stall = i_rd_stall;
`else
  assign rd_stall = 1'b0;
`endif

  assign cfg_ok = (cfg_wr_count != 8'd0) &&
                  (cfg_mode || ((cfg_kernel != 3'd0) && ({1'b0, cfg_kernel} <= cfg_map_w)));
  assign last_beat = wr_valid && (wr_cnt_q == n_q - 8'd1);
  // span is only meaningful once K <= M has been validated at start
  assign span      = m_q - {1'b0, k_q};
  assign k_last    = k_q - 3'd1;
  assign last_read = mode_q ? (lin_q == n_q - 8'd1)
                            : ((kx_q == k_last) && (ky_q == k_last) &&
                               (ox_q == span) && (oy_q == span));
  assign rd_go     = (state_q == S_DRAIN) && !rd_stall;

  assign row_a    = ADDR_W'(oy_q) + ADDR_W'(ky_q);
  assign col_a    = ADDR_W'(ox_q) + ADDR_W'(kx_q);
  assign win_addr = STRIDE_A * (row_a * ADDR_W'(m_q) + col_a);
  assign lin_addr = STRIDE_A * ADDR_W'(lin_q);

  always_ff @(posedge i_clk) begin
    if (!i_rst) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (i_start && cfg_ok) state_d = S_FILL;
      S_FILL:  if (last_beat) state_d = S_DRAIN;
      S_DRAIN: if (rd_go && last_read) state_d = S_FLUSH;
      S_FLUSH: state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    o_busy = (state_q != S_IDLE);
    o_done = (state_q == S_DONE);
  end

  always_comb begin
    mode_d = mode_q;  m_d = m_q;  k_d = k_q;  n_d = n_q;
    wr_cnt_d = wr_cnt_q;  lin_d = lin_q;
    oy_d = oy_q;  ox_d = ox_q;  ky_d = ky_q;  kx_d = kx_q;
    ena_d = 1'b0;  addra_d = addra_q;  dina_d = dina_q;
    enb_d = 1'b0;  addrb_d = addrb_q;
    rd_valid_d = enb_q;
    err_d = err_q;

    if (state_q == S_IDLE && i_start) begin
      mode_d = cfg_mode;  m_d = cfg_map_w;  k_d = cfg_kernel;  n_d = cfg_wr_count;
      wr_cnt_d = '0;  lin_d = '0;
      oy_d = '0;  ox_d = '0;  ky_d = '0;  kx_d = '0;
      err_d = !cfg_ok;
    end

    if (state_q == S_FILL && wr_valid) begin
      ena_d    = 1'b1;
      addra_d  = STRIDE_A * ADDR_W'(wr_cnt_q);
      dina_d   = wr_data;
      wr_cnt_d = wr_cnt_q + 8'd1;
    end

    // stray beats are dropped but flagged; this overrides the clear from a same-cycle start
    if (wr_valid && state_q != S_FILL) err_d = 1'b1;

    if (rd_go) begin
      enb_d = 1'b1;
      if (mode_q) begin
        addrb_d = lin_addr;
        lin_d   = lin_q + 8'd1;
      end else begin
        addrb_d = win_addr;
        if (kx_q != k_last) kx_d = kx_q + 3'd1;
        else begin
          kx_d = '0;
          if (ky_q != k_last) ky_d = ky_q + 3'd1;
          else begin
            ky_d = '0;
            if (ox_q != span) ox_d = ox_q + 4'd1;
            else begin
              ox_d = '0;
              oy_d = oy_q + 4'd1;
            end
          end
        end
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      mode_q <= 1'b0;  m_q <= '0;  k_q <= '0;  n_q <= '0;
      wr_cnt_q <= '0;  lin_q <= '0;
      oy_q <= '0;  ox_q <= '0;  ky_q <= '0;  kx_q <= '0;
      ena_q <= 1'b0;  addra_q <= '0;  dina_q <= '0;
      enb_q <= 1'b0;  addrb_q <= '0;
      rd_valid_q <= 1'b0;  err_q <= 1'b0;
    end else begin
      mode_q <= mode_d;  m_q <= m_d;  k_q <= k_d;  n_q <= n_d;
      wr_cnt_q <= wr_cnt_d;  lin_q <= lin_d;
      oy_q <= oy_d;  ox_q <= ox_d;  ky_q <= ky_d;  kx_q <= kx_d;
      ena_q <= ena_d;  addra_q <= addra_d;  dina_q <= dina_d;
      enb_q <= enb_d;  addrb_q <= addrb_d;
      rd_valid_q <= rd_valid_d;  err_q <= err_d;
    end
  end

  assign ena        = ena_q;
  assign wea        = ena_q;
  assign addra      = addra_q;
  assign dina       = dina_q;
  assign enb        = enb_q;
  assign addrb      = addrb_q;
  assign o_rd_valid = rd_valid_q;
  assign o_err      = err_q;

endmodule

// File: tb/tb_imme_buf_sched.sv
// Self-checking bench for imme_buf_sched: randomized passes checked against a loop-level
// reference of the write/read address sequences, plus error, protocol and reset scenarios.
module tb_imme_buf_sched;
  localparam int AW = 10;
  localparam int DW = 48;

  logic          i_clk = 1'b0;
  logic          i_rst = 1'b0;
  logic          i_start = 1'b0;
  logic          cfg_mode = 1'b0;
  logic [3:0]    cfg_map_w = '0;
  logic [2:0]    cfg_kernel = '0;
  logic [7:0]    cfg_wr_count = '0;
  logic          wr_valid = 1'b0;
  logic [DW-1:0] wr_data = '0;
`ifdef IMME_RD_STALL_EN
  logic          i_rd_stall = 1'b0;
`endif
  logic          ena, wea, enb, o_rd_valid, o_busy, o_done, o_err;
  logic [AW-1:0] addra, addrb;
  logic [DW-1:0] dina;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 i_clk = ~i_clk;

  imme_buf_sched dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start),
    .cfg_mode(cfg_mode), .cfg_map_w(cfg_map_w), .cfg_kernel(cfg_kernel),
    .cfg_wr_count(cfg_wr_count), .wr_valid(wr_valid), .wr_data(wr_data),
`ifdef IMME_RD_STALL_EN
    .i_rd_stall(i_rd_stall),
`endif
    .ena(ena), .wea(wea), .addra(addra), .dina(dina),
    .enb(enb), .addrb(addrb), .o_rd_valid(o_rd_valid),
    .o_busy(o_busy), .o_done(o_done), .o_err(o_err)
  );

  // Passive monitor: records every port-A write and port-B read, sampled on the falling edge.
  int            cyc = 0;
  logic [AW-1:0] mon_wa[$];
  logic [DW-1:0] mon_wd[$];
  int            mon_wc[$];
  logic [AW-1:0] mon_ra[$];
  int            mon_rc[$];
  int            rdv_cnt = 0, rdv_bad = 0, done_cnt = 0, overlap = 0, wea_bad = 0;
  logic          prev_enb = 1'b0;
  logic          rst_seen = 1'b1;

  always @(posedge i_clk) rst_seen = !i_rst;

  always @(negedge i_clk) begin
    cyc++;
    if (ena === 1'b1) begin
      mon_wa.push_back(addra);
      mon_wd.push_back(dina);
      mon_wc.push_back(cyc);
      if (wea !== 1'b1) wea_bad++;
    end
    if (enb === 1'b1) begin
      mon_ra.push_back(addrb);
      mon_rc.push_back(cyc);
    end
    if (o_rd_valid === 1'b1) rdv_cnt++;
    if (!rst_seen && (o_rd_valid !== prev_enb)) rdv_bad++;
    prev_enb = enb;
    if (ena === 1'b1 && enb === 1'b1) overlap++;
    if (o_done === 1'b1) done_cnt++;
  end

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic test_reset();
    i_rst = 1'b0; i_start = 1'b0; wr_valid = 1'b0;
    repeat (3) tick();
    n_checks++;
    if ({ena, wea, enb, o_rd_valid, o_busy, o_done, o_err} !== 7'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %b expected 0000000", {ena, wea, enb, o_rd_valid, o_busy, o_done, o_err});
    end
    n_checks++;
    if (addra !== '0 || addrb !== '0 || dina !== '0) begin
      n_fail++;
      $display("FAIL reset_data: got addra=%0d addrb=%0d dina=%h expected all 0", addra, addrb, dina);
    end
    i_rst = 1'b1;
    tick();
  endtask

  // One full layer pass; gap: 0 continuous, 1 alternate cycles, 2 random idles.
  task automatic run_pass(input string tag, input bit mode, input int m, input int k, input int n,
                          input int gap, input bit inj_start, input bit inj_stall);
    logic [AW-1:0] exp_rd[$];
    logic [DW-1:0] exp_wd[$];
    logic [DW-1:0] d;
    int w0 = mon_wa.size(), r0 = mon_ra.size();
    int v0 = rdv_cnt, vb0 = rdv_bad, d0 = done_cnt, ov0 = overlap, wb0 = wea_bad;
    int waited = 0, stall_left = 0, nw, nr, bad, first_bad, extra;
    bit injected = 0, stalled = 0;

    if (mode) begin
      for (int i = 0; i < n; i++) exp_rd.push_back(AW'(6 * i));
    end else begin
      for (int oy = 0; oy <= m - k; oy++)
        for (int ox = 0; ox <= m - k; ox++)
          for (int ky = 0; ky < k; ky++)
            for (int kx = 0; kx < k; kx++)
              exp_rd.push_back(AW'(6 * ((oy + ky) * m + ox + kx)));
    end

    cfg_mode = mode; cfg_map_w = 4'(m); cfg_kernel = 3'(k); cfg_wr_count = 8'(n);
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    n_checks++;
    if (o_busy !== 1'b1 || o_err !== 1'b0) begin
      n_fail++;
      $display("FAIL %s start: got busy=%b err=%b expected busy=1 err=0", tag, o_busy, o_err);
    end

    for (int i = 0; i < n; i++) begin
      int g;
      g = (gap == 1) ? 1 : ((gap == 2) ? int'($urandom_range(0, 2)) : 0);
      wr_valid = 1'b0;
      repeat (g) tick();
      d = {16'($urandom), 32'($urandom)};
      wr_valid = 1'b1; wr_data = d;
      exp_wd.push_back(d);
      tick();
    end
    wr_valid = 1'b0;

    while (done_cnt == d0 && waited < 8000) begin
      i_start = 1'b0;
      if (inj_start && !injected && (mon_ra.size() - r0) >= 50) begin
        cfg_mode = !mode; cfg_map_w = 4'd3; cfg_kernel = 3'd1; cfg_wr_count = 8'd2;
        i_start = 1'b1;
        injected = 1;
      end
`ifdef IMME_RD_STALL_EN
      i_rd_stall = 1'b0;
      if (inj_stall && !stalled && (mon_ra.size() - r0) >= 200) begin
        stalled = 1;
        stall_left = 3;
      end
      if (stall_left > 0) begin
        i_rd_stall = 1'b1;
        stall_left--;
      end
`endif
      tick();
      waited++;
    end
    i_start = 1'b0;
`ifdef IMME_RD_STALL_EN
    i_rd_stall = 1'b0;
`endif
    n_checks++;
    if (done_cnt == d0) begin
      n_fail++;
      $display("FAIL %s done_timeout: got no o_done after %0d cycles expected 1 o_done", tag, waited);
    end
    repeat (3) tick();

    nw = mon_wa.size() - w0;
    nr = mon_ra.size() - r0;
    n_checks++;
    if (nw != n) begin
      n_fail++;
      $display("FAIL %s write_count: got %0d expected %0d", tag, nw, n);
    end
    bad = 0; first_bad = -1;
    for (int i = 0; i < nw && i < n; i++)
      if (mon_wa[w0 + i] !== AW'(6 * i) || mon_wd[w0 + i] !== exp_wd[i]) begin
        bad++;
        if (first_bad < 0) first_bad = i;
      end
    n_checks++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL %s write_seq: entry %0d got addra=%0d dina=%h expected addra=%0d dina=%h",
               tag, first_bad, mon_wa[w0 + first_bad], mon_wd[w0 + first_bad], 6 * first_bad, exp_wd[first_bad]);
    end
    n_checks++;
    if (nr != exp_rd.size()) begin
      n_fail++;
      $display("FAIL %s read_count: got %0d expected %0d", tag, nr, exp_rd.size());
    end
    bad = 0; first_bad = -1;
    for (int i = 0; i < nr && i < exp_rd.size(); i++)
      if (mon_ra[r0 + i] !== exp_rd[i]) begin
        bad++;
        if (first_bad < 0) first_bad = i;
      end
    n_checks++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL %s read_seq: read %0d got addrb=%0d expected %0d (%0d wrong)",
               tag, first_bad, mon_ra[r0 + first_bad], exp_rd[first_bad], bad);
    end
    n_checks++;
    if (rdv_cnt - v0 != exp_rd.size() || rdv_bad != vb0) begin
      n_fail++;
      $display("FAIL %s rd_valid: got %0d pulses (%0d misaligned) expected %0d aligned", tag,
               rdv_cnt - v0, rdv_bad - vb0, exp_rd.size());
    end
    if (nw > 0 && nr > 0) begin
      extra = stalled ? 3 : 0;
      n_checks++;
      if (mon_rc[r0] != mon_wc[w0 + nw - 1] + 1) begin
        n_fail++;
        $display("FAIL %s first_read: got cycle %0d expected %0d", tag, mon_rc[r0], mon_wc[w0 + nw - 1] + 1);
      end
      n_checks++;
      if (mon_rc[r0 + nr - 1] - mon_rc[r0] != nr - 1 + extra) begin
        n_fail++;
        $display("FAIL %s read_span: got %0d cycles expected %0d", tag,
                 mon_rc[r0 + nr - 1] - mon_rc[r0], nr - 1 + extra);
      end
    end
    n_checks++;
    if (overlap != ov0 || wea_bad != wb0) begin
      n_fail++;
      $display("FAIL %s port_excl: got %0d overlaps %0d wea-low writes expected 0 0", tag,
               overlap - ov0, wea_bad - wb0);
    end
    n_checks++;
    if (done_cnt - d0 != 1 || o_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL %s done_once: got %0d pulses busy=%b expected 1 pulse busy=0", tag, done_cnt - d0, o_busy);
    end
    $display("pass %s: mode=%0d M=%0d K=%0d N=%0d writes=%0d reads=%0d", tag, mode, m, k, n, nw, nr);
  endtask

  task automatic test_window_full();
    run_pass("window_12_5", 1'b0, 12, 5, 144, 0, 1'b0, 1'b0);
  endtask

  task automatic test_linear_gapped();
    run_pass("linear_16", 1'b1, 0, 0, 16, 1, 1'b0, 1'b0);
  endtask

  task automatic test_random();
    for (int t = 0; t < 5; t++) begin
      bit md;
      int m, k, n;
      md = 1'($urandom_range(0, 1));
      m  = int'($urandom_range(1, 9));
      k  = int'($urandom_range(1, (m < 7) ? m : 7));
      n  = md ? int'($urandom_range(1, 60)) : m * m;
      run_pass("random", md, m, k, n, 2, 1'b0, 1'b0);
    end
  endtask

  task automatic test_cfg_err();
    cfg_mode = 1'b0; cfg_map_w = 4'd4; cfg_kernel = 3'd5; cfg_wr_count = 8'd16;
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    tick();
    n_checks++;
    if (o_err !== 1'b1 || o_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL cfg_k_gt_m: got err=%b busy=%b expected err=1 busy=0", o_err, o_busy);
    end
    cfg_mode = 1'b1; cfg_wr_count = 8'd0;
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    n_checks++;
    if (o_err !== 1'b1 || o_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL cfg_n_zero: got err=%b busy=%b expected err=1 busy=0", o_err, o_busy);
    end
    run_pass("after_cfg_err", 1'b0, 4, 3, 16, 0, 1'b0, 1'b0);
  endtask

  task automatic test_protocol();
    int w0;
    w0 = mon_wa.size();
    wr_valid = 1'b1; wr_data = 48'h1234_5678_9abc;
    tick();
    wr_valid = 1'b0;
    tick();
    n_checks++;
    if (o_err !== 1'b1 || mon_wa.size() != w0) begin
      n_fail++;
      $display("FAIL idle_beat: got err=%b writes=%0d expected err=1 writes=0", o_err, mon_wa.size() - w0);
    end
    run_pass("start_in_drain", 1'b0, 8, 3, 64, 0, 1'b1, 1'b0);
  endtask

  task automatic test_reset_mid_drain();
    int r0, d0, waited;
    r0 = mon_ra.size(); d0 = done_cnt; waited = 0;
    cfg_mode = 1'b0; cfg_map_w = 4'd12; cfg_kernel = 3'd5; cfg_wr_count = 8'd144;
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    wr_valid = 1'b1;
    for (int i = 0; i < 144; i++) begin
      wr_data = {16'($urandom), 32'($urandom)};
      tick();
    end
    wr_valid = 1'b0;
    while ((mon_ra.size() - r0) < 100 && waited < 2000) begin
      tick();
      waited++;
    end
    n_checks++;
    if ((mon_ra.size() - r0) < 100) begin
      n_fail++;
      $display("FAIL rst_drain_reach: got %0d reads expected at least 100", mon_ra.size() - r0);
    end
    i_rst = 1'b0;
    tick();
    n_checks++;
    if ({ena, wea, enb, o_rd_valid, o_busy, o_done, o_err} !== 7'b0 || addra !== '0 || addrb !== '0 || dina !== '0) begin
      n_fail++;
      $display("FAIL rst_drain_outputs: got ctrl=%b addra=%0d addrb=%0d expected all 0",
               {ena, wea, enb, o_rd_valid, o_busy, o_done, o_err}, addra, addrb);
    end
    i_rst = 1'b1;
    repeat (5) tick();
    n_checks++;
    if (done_cnt != d0 || o_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_drain_no_done: got %0d done pulses busy=%b expected 0 busy=0", done_cnt - d0, o_busy);
    end
    run_pass("after_reset", 1'b1, 0, 0, 20, 2, 1'b0, 1'b0);
  endtask

`ifdef IMME_RD_STALL_EN
  task automatic test_stall();
    run_pass("stall", 1'b0, 12, 5, 144, 0, 1'b0, 1'b1);
  endtask
`endif

  initial begin
    test_reset();
    test_window_full();
    test_linear_gapped();
    test_cfg_err();
    test_protocol();
    test_reset_mid_drain();
    test_random();
`ifdef IMME_RD_STALL_EN
    test_stall();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: got simulation still running expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/imme_buf_sched.md
Name: imme_buf_sched

Overview:
Scheduler for the 48-bit intermediate buffer BRAM (true dual-port) that sits between layers.
- Port A: collects pooled 3-channel results (3×16-bit packed) into BRAM, one entry per accepted beat.
- Port B: replays the stored map to the next layer, either as K×K sliding windows for a conv layer or as a linear sweep for an FC layer.
- Runs one layer pass per `i_start`, then pulses `o_done`.

Parameters:
- ADDR_W, 10, BRAM address width.
- DATA_W, 48, BRAM word width (3 channels × 16 bit).
- ADDR_STRIDE, 6, address increment per stored entry.

Ports:
- i_clk  in  1  clock
- i_rst  in  1  synchronous active-low reset
- i_start  in  1  pulse; latches cfg_* and begins a pass (accepted only in IDLE)
- cfg_mode  in  1  0 = WINDOW read, 1 = LINEAR read
- cfg_map_w  in  4  stored map width = height M (WINDOW mode)
- cfg_kernel  in  3  kernel size K (WINDOW mode)
- cfg_wr_count  in  8  number of entries N to collect
- wr_valid  in  1  write beat valid
- wr_data  in  DATA_W  packed {ch2, ch1, ch0}
- ena, wea  out  1  BRAM port-A enable / write enable
- addra  out  ADDR_W  port-A address
- dina  out  DATA_W  port-A data
- enb  out  1  BRAM port-B enable
- addrb  out  ADDR_W  port-B address
- o_rd_valid  out  1  high the cycle the BRAM doutb word is valid
- o_busy  out  1  high outside IDLE
- o_done  out  1  one-cycle pulse at end of pass
- o_err  out  1  sticky configuration/protocol error

Behaviour:
- Reset (i_rst=0 at a clock edge):
  - All outputs 0.
  - FSM goes to IDLE; all counters 0.
  - Reset mid-pass abandons the pass immediately. No o_done is generated.
- FSM states: IDLE → FILL → DRAIN → FLUSH → DONE → IDLE.
- IDLE:
  - On i_start, cfg_* is latched.
  - Invalid config, i.e. N=0, or in WINDOW mode K=0 or K>M: set o_err, stay in IDLE.
  - Valid config: clear o_err, go to FILL.
- FILL:
  - Each wr_valid beat produces a registered write the next cycle: ena=wea=1, addra=ADDR_STRIDE·wr_cnt, dina=wr_data; then wr_cnt increments.
  - ena/wea are low on cycles with no beat.
  - After beat N is accepted, the state moves to DRAIN. The transition takes effect on the same cycle the final write is committed.
- DRAIN, WINDOW mode:
  - Loop order, outermost first: oy 0..M−K, ox 0..M−K, ky 0..K−1, kx 0..K−1.
  - One read per cycle with enb=1 and addrb = ADDR_STRIDE·((oy+ky)·M + ox+kx). The address is registered.
  - Total reads = (M−K+1)²·K².
- DRAIN, LINEAR mode:
  - addrb = 0, STRIDE, … up to STRIDE·(N−1); N reads total.
- First enb is asserted the cycle after the last port-A write. There is no read-before-write of the final entry.
- o_rd_valid = enb delayed one cycle (BRAM read latency 1).
- After the last read issues, enb drops. FLUSH lasts 1 cycle so the final o_rd_valid appears. DONE then asserts o_done for 1 cycle and returns to IDLE.
- wr_valid outside FILL is dropped and sets o_err. The pass continues.
- i_start while busy is ignored.
- Port A and port B are never enabled in the same cycle.
- Address arithmetic uses ADDR_W bits. Results are truncated; no wrap detection beyond config checks.

Optional Feature:
- Macro: IMME_RD_STALL_EN.
- Defined:
  - Adds input port i_rd_stall (1 bit).
  - While i_rd_stall=1 in DRAIN: enb=0, all read counters and addrb hold, o_rd_valid follows enb as usual.
  - The stall is released on the next cycle with i_rd_stall=0, which resumes at the held address.
- Undefined: port absent; reads issue every DRAIN cycle without gaps.

Test Plan:
- WINDOW, M=12, K=5, N=144, continuous wr_valid:
  - addra runs 0..858 step 6.
  - 1600 reads with addrb sequence 0,6,12,18,24,72,78,… and last addrb=858.
  - Exactly 1600 o_rd_valid pulses, then 1 o_done.
- LINEAR, N=16, wr_valid gapped every other cycle:
  - 16 writes, addra 0..90.
  - Reads addrb 0,6,…,90 on consecutive cycles; 16 o_rd_valid, 1 o_done.
- Config errors:
  - i_start with K=5, M=4 → o_err=1, o_busy stays 0.
  - Next i_start with valid config clears o_err.
- Protocol:
  - wr_valid pulse in IDLE → o_err=1, no ena.
  - i_start during DRAIN → ignored; read sequence unchanged.
- Reset mid-DRAIN after 100 reads → next cycle all outputs 0, no o_done. A fresh pass then completes normally.
- With IMME_RD_STALL_EN, hold i_rd_stall for 3 cycles mid-window → enb low for 3 cycles, addrb resumes at the held value, total read count still 1600.
